mem_arbiter: RTL and testbench

Shares the CPU's single memory port between the instruction-fetch path (fed by the PC) and the load/store path (driven by ALU-computed addresses). It sequences each access through a fixed-latency memory and returns the read data to the winning requester with a one-cycle ready pulse. Data accesses win by default; a starvation guard bounds how long fetch can be locked out. It sits between the CPU datapath and a unified synchronous memory.

---
 rtl/mem_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one fixed-latency memory port between instruction fetch
// and load/store. Data wins by default. A consecutive-grant counter stops a
// stream of data accesses from locking fetch out indefinitely.
module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LAT      = 2,
  parameter int MAX_D_CONSEC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);
  localparam int DC_W  = $clog2(MAX_D_CONSEC + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state, nxt;
  logic [CNT_W-1:0]  cnt;
  logic [DC_W-1:0]   d_cnt;
  logic              sel_d;    // 1: current access belongs to the data port
  logic              we_q;     // current access is a store
  logic              grant;
  logic              grant_d;

  // Next-state and arbitration decision; arbitration only matters in IDLE.
  always_comb begin
    nxt     = state;
    grant   = 1'b0;
    grant_d = 1'b0;
    case (state)
      IDLE: begin
        if (i_req || d_req) begin
          nxt     = ISSUE;
          grant   = 1'b1;
          // Data wins unless fetch is pending and the data streak is used up.
          grant_d = d_req && (!i_req || (d_cnt < DC_W'(MAX_D_CONSEC)));
        end
      end
      ISSUE:   nxt = WAIT;
      WAIT:    if (cnt == CNT_W'(1)) nxt = RESP;
      RESP:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // Registered outputs, request latch, latency counter and data-streak count.
  always_ff @(posedge clk) begin
    if (rst) begin
      i_rdata   <= '0;
      d_rdata   <= '0;
      i_ready   <= 1'b0;
      d_ready   <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      cnt       <= '0;
      d_cnt     <= '0;
      sel_d     <= 1'b0;
      we_q      <= 1'b0;
    end else begin
      // Strobes and the memory bus default low; only ISSUE drives the bus.
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_ready   <= 1'b0;
      d_ready   <= 1'b0;
      busy      <= (nxt != IDLE);
      case (state)
        IDLE: begin
          if (grant) begin
            sel_d     <= grant_d;
            we_q      <= grant_d & d_we;
            mem_en    <= 1'b1;
            mem_we    <= grant_d & d_we;
            mem_addr  <= grant_d ? d_addr : i_addr;
            mem_wdata <= grant_d ? d_wdata : '0;
            // Streak only grows while fetch is actually being held off.
            if (grant_d) d_cnt <= i_req ? d_cnt + 1'b1 : '0;
            else         d_cnt <= '0;
          end
        end
        ISSUE: cnt <= CNT_W'(MEM_LAT);
        WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            if (!sel_d)     i_rdata <= mem_rdata;
            else if (!we_q) d_rdata <= mem_rdata;
            i_ready <= !sel_d;
            d_ready <= sel_d;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter. Instance 0 uses MEM_LAT=2,
// instances 1 and 2 use MEM_LAT=1 and 5. Each has its own memory model that
// returns real data exactly MEM_LAT cycles after mem_en and junk otherwise.
module tb_mem_arbiter;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req [N];
  logic        d_req [N];
  logic        d_we  [N];
  logic [31:0] i_addr [N];
  logic [31:0] d_addr [N];
  logic [31:0] d_wdata [N];
  logic [31:0] i_rdata [N];
  logic [31:0] d_rdata [N];
  logic        i_ready [N];
  logic        d_ready [N];
  logic        mem_en [N];
  logic        mem_we [N];
  logic [31:0] mem_addr [N];
  logic [31:0] mem_wdata [N];
  logic [31:0] mem_rdata [N];
  logic        busy [N];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] memval(input logic [31:0] a);
    return (a == 32'h10) ? 32'hAABBCCDD : {16'hC0DE, a[15:0]};
  endfunction

  for (genvar g = 0; g < N; g++) begin : gi
    localparam int LAT = (g == 0) ? 2 : (g == 1) ? 1 : 5;
    logic [31:0] pipe [1:15];
    logic [15:0] junk = '0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .MAX_D_CONSEC(4)) u_dut (
      .clk(clk), .rst(rst),
      .i_req(i_req[g]), .i_addr(i_addr[g]), .i_rdata(i_rdata[g]), .i_ready(i_ready[g]),
      .d_req(d_req[g]), .d_we(d_we[g]), .d_addr(d_addr[g]), .d_wdata(d_wdata[g]),
      .d_rdata(d_rdata[g]), .d_ready(d_ready[g]),
      .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
      .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g]), .busy(busy[g])
    );

    // Read-latency model: valid data only in the cycle MEM_LAT after mem_en.
    always @(posedge clk) begin
      junk    <= junk + 16'd1;
      pipe[1] <= (mem_en[g] && !mem_we[g]) ? memval(mem_addr[g]) : {16'hBAD0, junk};
      for (int k = 2; k <= 15; k++) pipe[k] <= pipe[k-1];
    end
    assign mem_rdata[g] = pipe[LAT];
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Captured by wait_any for the first mem_en seen during the wait.
  int          en_at;
  logic [31:0] en_addr, en_wdata;
  logic        en_we;
  logic        bus_nz;

  // Step negedges until either ready pulses (bounded); n = cycles waited,
  // who = 1 fetch, 2 data, 3 both.
  task automatic wait_any(input int g, output int n, output int who);
    n = -1; who = 0; en_at = -1; bus_nz = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (mem_en[g] && en_at < 0) begin
        en_at = c; en_addr = mem_addr[g]; en_we = mem_we[g]; en_wdata = mem_wdata[g];
      end
      if (!mem_en[g] && (mem_we[g] || mem_addr[g] != 0 || mem_wdata[g] != 0)) bus_nz = 1'b1;
      if (i_ready[g] || d_ready[g]) begin
        n = c;
        who = 2 * int'(d_ready[g]) + int'(i_ready[g]);
        break;
      end
    end
  endtask

  initial begin
    int n, who;
    int exp_who [10];
    exp_who = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};
    rst = 1'b1;
    for (int g = 0; g < N; g++) begin
      i_req[g] = 1'b0; d_req[g] = 1'b0; d_we[g] = 1'b0;
      i_addr[g] = '0; d_addr[g] = '0; d_wdata[g] = '0;
    end
    // Reset held with requests pending
    i_req[0] = 1'b1; d_req[0] = 1'b1; i_addr[0] = 32'h10; d_addr[0] = 32'h20;
    repeat (3) @(negedge clk);
    chk("rst_ctl", {i_ready[0], d_ready[0], mem_en[0], mem_we[0], busy[0]}, 0);
    chk("rst_addr", mem_addr[0], 0);
    chk("rst_wdata", mem_wdata[0], 0);
    chk("rst_rdata", {i_rdata[0], d_rdata[0]}, 0);
    rst = 1'b0; d_req[0] = 1'b0; d_addr[0] = '0;
    wait_any(0, n, who);
    i_req[0] = 1'b0;
    chk("rel_en_cyc", en_at, 1);
    chk("rel_en_addr", en_addr, 32'h10);
    chk("rel_rdy_cyc", n, 4);
    chk("rel_who", who, 1);
    chk("rel_rdata", i_rdata[0], 32'hAABBCCDD);
    @(negedge clk);
    chk("idle_busy", busy[0], 0);

    // Simultaneous load + fetch: data first, fetch after
    i_req[0] = 1'b1; i_addr[0] = 32'h30;
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h20;
    wait_any(0, n, who);
    d_req[0] = 1'b0;
    chk("sim_d_en", en_at, 1);
    chk("sim_d_addr", en_addr, 32'h20);
    chk("sim_d_rdy", n, 4);
    chk("sim_d_who", who, 2);
    chk("sim_d_rdata", d_rdata[0], 32'hC0DE0020);
    wait_any(0, n, who);
    i_req[0] = 1'b0;
    chk("sim_i_en", 4 + en_at, 6);
    chk("sim_i_rdy", 4 + n, 9);
    chk("sim_i_who", who, 1);
    chk("sim_i_rdata", i_rdata[0], 32'hC0DE0030);
    @(negedge clk);

    // Store: bus carries we/addr/data, load data register untouched
    d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 32'h40; d_wdata[0] = 32'h12345678;
    wait_any(0, n, who);
    d_req[0] = 1'b0; d_we[0] = 1'b0;
    chk("st_en", en_at, 1);
    chk("st_we", en_we, 1);
    chk("st_addr", en_addr, 32'h40);
    chk("st_wdata", en_wdata, 32'h12345678);
    chk("st_bus_idle", bus_nz, 0);
    chk("st_rdy", n, 4);
    chk("st_who", who, 2);
    chk("st_rdata_kept", d_rdata[0], 32'hC0DE0020);
    @(negedge clk);

    // Starvation guard: both held, 4 data grants then one fetch, repeating
    i_req[0] = 1'b1; i_addr[0] = 32'h80;
    d_req[0] = 1'b1; d_addr[0] = 32'h84;
    for (int k = 0; k < 10; k++) begin
      wait_any(0, n, who);
      chk($sformatf("stv_who%0d", k), who, exp_who[k]);
      chk($sformatf("stv_gap%0d", k), n, (k == 0) ? 4 : 5);
    end
    i_req[0] = 1'b0; d_req[0] = 1'b0;
    chk("stv_i_rdata", i_rdata[0], 32'hC0DE0080);
    chk("stv_d_rdata", d_rdata[0], 32'hC0DE0084);
    @(negedge clk);

    // Reset during WAIT of a load: no ready, IDLE next, reissue completes
    d_req[0] = 1'b1; d_addr[0] = 32'h50;
    @(negedge clk);
    chk("mid_en", mem_en[0], 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_ctl", {d_ready[0], i_ready[0], busy[0], mem_en[0]}, 0);
    chk("mid_rst_rdata", d_rdata[0], 0);
    rst = 1'b0;
    wait_any(0, n, who);
    d_req[0] = 1'b0;
    chk("mid_re_en", en_at, 1);
    chk("mid_re_rdy", n, 4);
    chk("mid_re_who", who, 2);
    chk("mid_re_rdata", d_rdata[0], 32'hC0DE0050);
    @(negedge clk);

    // MEM_LAT=1 fetch
    i_req[1] = 1'b1; i_addr[1] = 32'h60;
    wait_any(1, n, who);
    i_req[1] = 1'b0;
    chk("lat1_en", en_at, 1);
    chk("lat1_rdy", n, 3);
    chk("lat1_who", who, 1);
    chk("lat1_rdata", i_rdata[1], 32'hC0DE0060);
    @(negedge clk);

    // MEM_LAT=5 load
    d_req[2] = 1'b1; d_addr[2] = 32'h70;
    wait_any(2, n, who);
    d_req[2] = 1'b0;
    chk("lat5_en", en_at, 1);
    chk("lat5_rdy", n, 7);
    chk("lat5_who", who, 2);
    chk("lat5_rdata", d_rdata[2], 32'hC0DE0070);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
